// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO), one iteration per cycle.
// Optional MDU_EARLY_TERM_EN: multiply finishes once the remaining multiplier magnitude is zero.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;   // product (mult) or remainder in low half (div)
    logic [WIDTH-1:0]   x_q, x_d;       // multiplier (mult) or dividend->quotient (div)
    logic [2*WIDTH-1:0] y_q, y_d;       // shifting multiplicand (mult) or divisor (div)
    logic [WIDTH-1:0]   a_q, a_d;
    logic               is_div_q, is_div_d;
    logic               res_neg_q, res_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_m, y_m, prod;
    logic [WIDTH-1:0]   x_m, rem_n, quo_n;
    logic [WIDTH:0]     rem_sh;
    logic               ge, div0, last;

    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;

        // shift-add multiply step
        acc_m = acc_q + (x_q[0] ? y_q : '0);
        x_m   = x_q >> 1;
        y_m   = y_q << 1;
        prod  = res_neg_q ? -acc_m : acc_m;

        // restoring divide step
        rem_sh = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
        ge     = rem_sh >= {1'b0, y_q[WIDTH-1:0]};
        rem_n  = ge ? WIDTH'(rem_sh - {1'b0, y_q[WIDTH-1:0]}) : rem_sh[WIDTH-1:0];
        quo_n  = {x_q[WIDTH-2:0], ge};
        div0   = (y_q[WIDTH-1:0] == '0);

        last = (cnt_q == CW'(WIDTH - 1));
`ifdef MDU_EARLY_TERM_EN
        if (!is_div_q && x_m == '0) last = 1'b1;
`endif

        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        x_d       = x_q;
        y_d       = y_q;
        a_d       = a_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    acc_d     = '0;
                    a_d       = a;
                    is_div_d  = op[1];
                    res_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    if (op[1]) begin
                        x_d = a_mag;
                        y_d = {{WIDTH{1'b0}}, b_mag};
                    end else begin
                        x_d = b_mag;
                        y_d = {{WIDTH{1'b0}}, a_mag};
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_d) begin
                    acc_d = {{WIDTH{1'b0}}, rem_n};
                    x_d   = quo_n;
                end else begin
                    acc_d = acc_m;
                    x_d   = x_m;
                    y_d   = y_m;
                end
                // signs are applied while moving the final iteration into hi/lo
                if (last) begin
                    state_d = DONE;
                    dbz_d   = 1'b0;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod;
                    end else if (div0) begin
                        hi_d  = a_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = res_neg_q ? -quo_n : quo_n;
                        hi_d = rem_neg_q ? -rem_n : rem_n;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            a_q       <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            y_q       <= y_d;
            a_q       <= a_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign div_by_zero = (state_q == DONE) & dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule
